// File: rtl/data_out_ser.sv
// Byte-serial readback of one of four configuration sources over a valid/ready port.
// A request snapshots the chosen source, then streams its bytes LSB first, then pulses done.
module data_out_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_start,
    input  logic [1:0]  rd_sel,
    input  logic [31:0] sram_trunc_in,
    input  logic [4:0]  trunc_sel_in,
    input  logic [9:0]  sram_priv_in,
    input  logic [9:0]  word_sel_in,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic [1:0]  byte_idx,
    output logic        busy,
    output logic        done,
    output logic        rd_err,
    output logic [1:0]  state_o
);

    // Handshake: a byte moves on a rising edge where data_out_valid and
    // data_out_ready are both 1; while valid=1 and ready=0 data_out/byte_idx hold.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] hold_q;
    logic [1:0]  last_q;
    logic [1:0]  idx_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] snap_d;
    logic [1:0]  last_d;
    logic [1:0]  idx_d;
    logic [7:0]  byte_d;

    always_comb begin
        snap_d = 32'h0;
        last_d = 2'd0;
        case (rd_sel)
            2'b00: begin
                snap_d = sram_trunc_in;
                last_d = 2'd3;
            end
            2'b01: begin
                snap_d = {27'h0, trunc_sel_in};
                last_d = 2'd0;
            end
            2'b10: begin
                snap_d = {22'h0, sram_priv_in};
                last_d = 2'd1;
            end
            default: begin
                snap_d = {22'h0, word_sel_in};
                last_d = 2'd1;
            end
        endcase
    end

    assign idx_d = idx_q + 2'd1;

    // Byte offered after the current one is accepted, taken from the snapshot only.
    always_comb begin
        byte_d = 8'h00;
        case (idx_d)
            2'd0:    byte_d = hold_q[7:0];
            2'd1:    byte_d = hold_q[15:8];
            2'd2:    byte_d = hold_q[23:16];
            default: byte_d = hold_q[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 32'h0;
            last_q  <= 2'd0;
            idx_q   <= 2'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= rd_start && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (rd_start) begin
                        state_q <= SEND;
                        hold_q  <= snap_d;
                        last_q  <= last_d;
                        idx_q   <= 2'd0;
                        data_q  <= snap_d[7:0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (valid_q && data_out_ready) begin
                        if (idx_q == last_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            data_q  <= 8'h00;
                            idx_q   <= 2'd0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_d;
                            data_q <= byte_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                    idx_q   <= 2'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign byte_idx       = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_err         = err_q;
    assign state_o        = state_q;

endmodule
